// File: rtl/uart_serial_port.sv
// rtl/uart_serial_port.sv - full-duplex 8N1 UART with ready/valid byte interfaces
//
// Optional feature macro: UART_LOOPBACK_EN (adds the loopback input).
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous active-low reset
//   data_in         byte to transmit
//   data_in_valid   transmit request
//   data_in_ready   transmitter idle, accepts a byte
//   data_out        last good received byte
//   data_out_valid  data_out holds an unconsumed byte
//   data_out_ready  consumer accepts data_out
//   serial_in       RX line, idle high
//   serial_out      TX line, idle high
//   loopback        (UART_LOOPBACK_EN only) route TX into RX, hold serial_out high
module uart_serial_port #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    input  logic       serial_in,
    output logic       serial_out
`ifdef UART_LOOPBACK_EN
    ,
    input  logic       loopback
`endif
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CW               = $clog2(SYMBOL_EDGE_TIME) + 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] MID_LAST = CW'(SAMPLE_TIME - 1);

    // ---------------- transmitter ----------------
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    tx_state_t     tx_state_q;
    logic [9:0]    tx_frame_q;
    logic [3:0]    tx_bit_q;
    logic [CW-1:0] tx_cnt_q;
    logic          tx_line_q;
    logic          tx_ready_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_frame_q <= '0;
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
            tx_line_q  <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (data_in_valid) begin
                        // Start bit goes out on the handshake edge itself.
                        tx_frame_q <= {1'b1, data_in, 1'b0};
                        tx_line_q  <= 1'b0;
                        tx_ready_q <= 1'b0;
                        tx_bit_q   <= '0;
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 4'd9) begin
                            tx_state_q <= TX_IDLE;
                            tx_ready_q <= 1'b1;
                            tx_line_q  <= 1'b1;
                        end else begin
                            // frame_q[0] is the bit on the line; [1] is the next one.
                            tx_bit_q   <= tx_bit_q + 4'd1;
                            tx_line_q  <= tx_frame_q[1];
                            tx_frame_q <= {1'b1, tx_frame_q[9:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CW'(1);
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign data_in_ready = tx_ready_q;

    logic rx_src;
`ifdef UART_LOOPBACK_EN
    assign rx_src     = loopback ? tx_line_q : serial_in;
    assign serial_out = loopback ? 1'b1 : tx_line_q;
`else
    assign rx_src     = serial_in;
    assign serial_out = tx_line_q;
`endif

    // ---------------- receiver ----------------
    typedef enum logic {RX_IDLE, RX_RECEIVE} rx_state_t;

    rx_state_t     rx_state_q;
    logic          rx_sync1_q;
    logic          rx_sync2_q;
    logic [3:0]    rx_bit_q;
    logic [CW-1:0] rx_cnt_q;
    logic [7:0]    rx_shift_q;
    logic          rx_break_q;   // framing error seen, wait for line high
    logic [7:0]    dout_q;
    logic          dout_valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q   <= RX_IDLE;
            rx_sync1_q   <= 1'b1;
            rx_sync2_q   <= 1'b1;
            rx_bit_q     <= '0;
            rx_cnt_q     <= '0;
            rx_shift_q   <= '0;
            rx_break_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            rx_sync1_q <= rx_src;
            rx_sync2_q <= rx_sync1_q;

            if (dout_valid_q && data_out_ready) begin
                dout_valid_q <= 1'b0;
            end

            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_break_q) begin
                        if (rx_sync2_q) rx_break_q <= 1'b0;
                    end else if (!rx_sync2_q && !dout_valid_q) begin
                        // A held byte blocks reception, so it is never overwritten.
                        rx_state_q <= RX_RECEIVE;
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                    end
                end
                RX_RECEIVE: begin
                    if (rx_bit_q == 4'd0) begin
                        if (rx_cnt_q == MID_LAST) begin
                            rx_cnt_q <= '0;
                            if (rx_sync2_q) rx_state_q <= RX_IDLE;   // glitch
                            else            rx_bit_q   <= 4'd1;
                        end else begin
                            rx_cnt_q <= rx_cnt_q + CW'(1);
                        end
                    end else if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        if (rx_bit_q == 4'd9) begin
                            rx_state_q <= RX_IDLE;
                            if (rx_sync2_q) begin
                                dout_q       <= rx_shift_q;
                                dout_valid_q <= 1'b1;
                            end else begin
                                rx_break_q <= 1'b1;
                            end
                        end else begin
                            rx_shift_q <= {rx_sync2_q, rx_shift_q[7:1]};
                            rx_bit_q   <= rx_bit_q + 4'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign data_out       = dout_q;
    assign data_out_valid = dout_valid_q;

endmodule

// File: tb/tb_uart_serial_port.sv
// tb/tb_uart_serial_port.sv - directed bench for uart_serial_port (two cross-connected instances)
module tb_uart_serial_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] a_din, b_din;
    logic       a_din_valid, b_din_valid;
    logic       a_din_ready, b_din_ready;
    logic [7:0] a_dout, b_dout;
    logic       a_dout_valid, b_dout_valid;
    logic       a_dout_ready, b_dout_ready;
    logic       a_tx, b_tx;
    logic       b_rx;
    logic       use_man;
    logic       man_line;

    assign b_rx = use_man ? man_line : a_tx;

    uart_serial_port #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(12_500_000)) u_a (
        .clk(clk), .reset(rst_n),
        .data_in(a_din), .data_in_valid(a_din_valid), .data_in_ready(a_din_ready),
        .data_out(a_dout), .data_out_valid(a_dout_valid), .data_out_ready(a_dout_ready),
        .serial_in(b_tx), .serial_out(a_tx)
`ifdef UART_LOOPBACK_EN
        , .loopback(1'b0)
`endif
    );

    uart_serial_port #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(12_500_000)) u_b (
        .clk(clk), .reset(rst_n),
        .data_in(b_din), .data_in_valid(b_din_valid), .data_in_ready(b_din_ready),
        .data_out(b_dout), .data_out_valid(b_dout_valid), .data_out_ready(b_dout_ready),
        .serial_in(b_rx), .serial_out(b_tx)
`ifdef UART_LOOPBACK_EN
        , .loopback(1'b0)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input bit on_a, input string tag);
        int n = 0;
        while (((on_a ? a_dout_valid : b_dout_valid) !== 1'b1) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, on_a ? a_dout_valid : b_dout_valid, 8'd1);
    endtask

    task automatic send_a(input logic [7:0] d);
        int n = 0;
        while (a_din_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        a_din = d; a_din_valid = 1'b1;
        @(negedge clk);
        a_din_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        int n = 0;
        while (b_din_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        b_din = d; b_din_valid = 1'b1;
        @(negedge clk);
        b_din_valid = 1'b0;
    endtask

    task automatic consume(input bit on_a, input string tag);
        if (on_a) a_dout_ready = 1'b1; else b_dout_ready = 1'b1;
        @(negedge clk);
        a_dout_ready = 1'b0; b_dout_ready = 1'b0;
        check(tag, on_a ? a_dout_valid : b_dout_valid, 8'd0);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            man_line = f[i];
            repeat (4) @(negedge clk);
        end
    endtask

    logic [9:0] tx_exp;

    initial begin
        rst_n = 1'b0;
        a_din = '0; b_din = '0;
        a_din_valid = 1'b0; b_din_valid = 1'b0;
        a_dout_ready = 1'b0; b_dout_ready = 1'b0;
        use_man = 1'b0; man_line = 1'b1;

        repeat (30) @(negedge clk);
        check("rst_hold_tx", a_tx, 8'd1);
        check("rst_hold_ready", a_din_ready, 8'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tx", a_tx, 8'd1);
        check("rst_ready", a_din_ready, 8'd1);
        check("rst_valid", a_dout_valid, 8'd0);
        check("rst_dout", a_dout, 8'h00);
        check("rst_b_valid", b_dout_valid, 8'd0);

        // TX frame 8'h7A: line 0,0,1,0,1,1,1,1,0,1, four clocks per bit
        tx_exp = {1'b1, 8'h7A, 1'b0};
        a_din = 8'h7A; a_din_valid = 1'b1;
        @(negedge clk);
        a_din_valid = 1'b0; a_din = 8'hFF;
        for (int i = 0; i < 40; i++) begin
            check($sformatf("tx_bit%0d", i), a_tx, {7'd0, tx_exp[i/4]});
            check($sformatf("tx_busy%0d", i), a_din_ready, 8'd0);
            @(negedge clk);
        end
        check("tx_ready_back", a_din_ready, 8'd1);
        check("tx_idle_line", a_tx, 8'd1);
        wait_valid(1'b0, "b_valid_7a");
        check("b_data_7a", b_dout, 8'h7A);

        // Echo back from B to A
        send_b(8'h7A);
        consume(1'b0, "b_clear_7a");
        wait_valid(1'b1, "a_valid_echo");
        check("a_data_echo", a_dout, 8'h7A);
        consume(1'b1, "a_clear_echo");
        check("a_data_kept", a_dout, 8'h7A);

        // Second byte
        send_a(8'h61);
        wait_valid(1'b0, "b_valid_61");
        check("b_data_61", b_dout, 8'h61);
        consume(1'b0, "b_clear_61");

        // Overrun: held byte is never overwritten
        send_a(8'h55);
        wait_valid(1'b0, "b_valid_55");
        check("b_data_55", b_dout, 8'h55);
        send_a(8'hAA);
        repeat (60) @(negedge clk);
        check("ovr_data", b_dout, 8'h55);
        check("ovr_valid", b_dout_valid, 8'd1);
        consume(1'b0, "b_clear_55");
        send_a(8'h3C);
        wait_valid(1'b0, "b_valid_3c");
        check("b_data_3c", b_dout, 8'h3C);
        consume(1'b0, "b_clear_3c");

        // Glitch on the line
        repeat (20) @(negedge clk);
        use_man = 1'b1;
        repeat (4) @(negedge clk);
        man_line = 1'b0;
        @(negedge clk);
        man_line = 1'b1;
        repeat (50) @(negedge clk);
        check("glitch_valid", b_dout_valid, 8'd0);

        // Framing error, line held low after the bad stop bit
        drive_frame(8'hA5, 1'b0);
        man_line = 1'b0;
        repeat (12) @(negedge clk);
        man_line = 1'b1;
        repeat (12) @(negedge clk);
        check("ferr_valid", b_dout_valid, 8'd0);
        check("ferr_data", b_dout, 8'h3C);

        // Good frame after the framing error
        drive_frame(8'hC3, 1'b1);
        wait_valid(1'b0, "b_valid_c3");
        check("b_data_c3", b_dout, 8'hC3);
        consume(1'b0, "b_clear_c3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_serial_port.md
Name: uart_serial_port

Overview:
- Full-duplex 8N1 UART with ready/valid byte interfaces on both directions.
- Used as the CPU's on-chip UART, exposed through memory-mapped IO.
- Also used as the off-chip bench UART.
- Transmit path serialises a parallel byte onto serial_out; receive path deserialises serial_in into a held byte.

Parameters:
- CLOCK_FREQ, 125_000_000: clk frequency in Hz.
- BAUD_RATE, 115_200: line rate in bits/s.
- SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (integer division): clocks per bit. Derived localparam, not overridable.
- SAMPLE_TIME = SYMBOL_EDGE_TIME/2: clocks from bit start to mid-bit sample. Derived localparam.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- data_in  input  8  byte to transmit.
- data_in_valid  input  1  transmit request.
- data_in_ready  output  1  transmitter idle, can accept a byte.
- data_out  output  8  last received byte.
- data_out_valid  output  1  data_out holds an unconsumed byte.
- data_out_ready  input  1  consumer accepts data_out.
- serial_in  input  1  RX line, idle high.
- serial_out  output  1  TX line, idle high; registered.

Behaviour:
- Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts SYMBOL_EDGE_TIME clocks.
- Reset values while reset=0: serial_out=1, data_in_ready=1, data_out=8'h00, data_out_valid=0. All counters and shift registers clear; RX returns to idle.
- TX states: IDLE, SEND (bit index 0..9, per-bit clock counter).
- TX handshake: data_in_valid & data_in_ready at rising edge k latches data_in.
  - data_in_ready drops at edge k; serial_out=0 (start bit) from edge k.
  - Each bit is held exactly SYMBOL_EDGE_TIME cycles.
  - The stop bit ends at edge k+10*SYMBOL_EDGE_TIME, where data_in_ready returns to 1 and serial_out stays 1.
  - data_in changes after the handshake do not affect the frame in flight.
  - data_in_valid while not ready is ignored (no queueing).
- RX front end: serial_in passes through a 2-flop synchroniser, reset to 1. All RX decisions use the synchronised value.
- RX states: IDLE, RECEIVE.
  - IDLE -> RECEIVE on synchronised 0, but only when data_out_valid=0.
  - While data_out_valid=1, incoming frames are ignored and dropped; the held byte is never overwritten.
- RX sampling:
  - Start bit re-sampled at SAMPLE_TIME; if it reads 1, treat as glitch and return to IDLE.
  - Data bits sampled at mid-bit, SAMPLE_TIME + n*SYMBOL_EDGE_TIME after the falling edge, n=1..8, shifted in LSB first.
  - Stop bit sampled at mid-bit.
- RX completion:
  - Stop=1: data_out loads the byte and data_out_valid rises on the following edge; return to IDLE.
  - Stop=0 (framing error): byte discarded, data_out_valid stays 0, return to IDLE after the line returns high.
- RX consume: data_out_valid & data_out_ready at an edge clears data_out_valid. data_out keeps its value until the next good frame.
  - If a new frame completes in the same cycle data_out_ready clears valid: impossible by construction, since RX is blocked while valid=1.
- TX and RX are fully independent; simultaneous activity is allowed.
- Reset asserted mid-frame aborts immediately. serial_out goes 1 asynchronously and no partial byte is reported.

Optional Feature:
- Macro UART_LOOPBACK_EN.
- When defined: extra input port loopback (1 bit).
  - loopback=1: RX synchroniser input is driven by the internal TX line instead of serial_in, and serial_out is forced to 1.
  - loopback=0: normal operation.
- When undefined: no loopback port; serial_in feeds RX directly.

Test Plan:
- Reset: hold reset=0 for 30 cycles, release -> serial_out=1, data_in_ready=1, data_out_valid=0, data_out=8'h00.
- TX frame (CLOCK_FREQ=50_000_000, BAUD_RATE=12_500_000, so 4 clk/bit): send 8'h7A -> serial_out sequence 0,0,1,0,1,1,1,1,0,1, each held 4 cycles. data_in_ready is low for exactly 40 cycles.
- Echo pair: two instances cross-connected (serial_out A -> serial_in B). A sends 8'h7A -> B data_out_valid=1 with data_out=8'h7A within 50 cycles. B echoes back to A, then pulse data_out_ready on A.
- Second byte: after clearing data_out_valid, send 8'h61 -> receiver reports 8'h61. Valid clears one cycle after the data_out_ready pulse.
- Overrun: receive 8'h55, leave data_out_ready=0, send 8'hAA -> data_out stays 8'h55 and valid stays 1. After consuming, a third byte 8'h3C is received correctly.
- Framing/glitch: drive a 1-cycle low pulse on serial_in -> no valid. Send a frame with stop bit 0 -> no valid; the following good frame 8'hC3 is received.
